// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks.
// Direction, coordinate and FSM encodings used by body, apple and render.
package snake_pkg;

  localparam int X_W   = 7;
  localparam int Y_W   = 6;
  localparam int LEN_W = 5;

  localparam int GRID_W_DEF = 64;
  localparam int GRID_H_DEF = 48;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DEAD = 2'b10;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  // Opposite directions differ only in the upper bit.
  function automatic logic [1:0] dir_opp(
    input logic [1:0] d
  );
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Masked equality of one cell against the first count segments.
// Shared by the self-collision check and the renderer query.
module snake_seg_match
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic [MAX_LEN-1:0][X_W-1:0] seg_x,
  input  logic [MAX_LEN-1:0][Y_W-1:0] seg_y,
  input  logic [LEN_W-1:0]            count,
  input  logic [X_W-1:0]              px,
  input  logic [Y_W-1:0]              py,
  output logic                        hit
);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(count)
          && seg_x[k] == px
          && seg_y[k] == py) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body.sv
// Snake head movement, body shift register, growth and collisions.
// Also answers the renderer's registered "is this cell snake" query.
module snake_body
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 10,
  parameter int START_Y  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  input  logic [1:0]       dir_in,
  input  logic [X_W-1:0]   apple_x,
  input  logic [Y_W-1:0]   apple_y,
  input  logic [X_W-1:0]   query_x,
  input  logic [Y_W-1:0]   query_y,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] length,
  output logic             ate,
  output logic             alive,
  output logic             game_over,
  output logic             query_hit
);

  localparam logic [LEN_W-1:0] LEN_MAX  =
    LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_INIT =
    LEN_W'(INIT_LEN);

  logic [1:0] state;
  logic [1:0] dir;
  logic [1:0] last_dir;
  logic [1:0] applied;

  logic [MAX_LEN-1:0][X_W-1:0] seg_x;
  logic [MAX_LEN-1:0][Y_W-1:0] seg_y;
  logic [LEN_W-1:0]            len;
  logic [LEN_W-1:0]            self_cnt;

  cell_t nxt;
  logic  run;
  logic  launch;
  logic  step_run;
  logic  wall;
  logic  apple_eq;
  logic  grow;
  logic  self_hit;
  logic  collide;
  logic  q_hit;

  assign run      = state == ST_RUN;
  assign launch   = start && !run;
  assign step_run = run && step;

  // Wall test looks at the current head so nothing wraps.
  always_comb begin
    nxt.x = seg_x[0];
    nxt.y = seg_y[0];
    wall  = 1'b0;
    unique case (1'b1)
      dir == DIR_UP: begin
        wall  = seg_y[0] == '0;
        nxt.y = seg_y[0] - Y_W'(1);
      end
      dir == DIR_RIGHT: begin
        wall  = int'(seg_x[0]) >= GRID_W - 1;
        nxt.x = seg_x[0] + X_W'(1);
      end
      dir == DIR_DOWN: begin
        wall  = int'(seg_y[0]) >= GRID_H - 1;
        nxt.y = seg_y[0] + Y_W'(1);
      end
      dir == DIR_LEFT: begin
        wall  = seg_x[0] == '0;
        nxt.x = seg_x[0] - X_W'(1);
      end
      default: ;
    endcase
  end

  assign apple_eq = nxt.x == apple_x
                 && nxt.y == apple_y;
  assign grow     = apple_eq && len < LEN_MAX;

  // A growing snake keeps its tail, so the tail cell blocks too.
  always_comb begin
    self_cnt = '0;
    if (grow) begin
      self_cnt = len;
    end else if (len != '0) begin
      self_cnt = len - LEN_W'(1);
    end
  end

  snake_seg_match #(
    .MAX_LEN (MAX_LEN)
  ) u_self (
    .seg_x (seg_x),
    .seg_y (seg_y),
    .count (self_cnt),
    .px    (nxt.x),
    .py    (nxt.y),
    .hit   (self_hit)
  );

  snake_seg_match #(
    .MAX_LEN (MAX_LEN)
  ) u_query (
    .seg_x (seg_x),
    .seg_y (seg_y),
    .count (len),
    .px    (query_x),
    .py    (query_y),
    .hit   (q_hit)
  );

  assign collide = wall || self_hit;
  assign applied = step_run ? dir : last_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (launch) begin
      state <= ST_RUN;
    end else if (step_run && collide) begin
      state <= ST_DEAD;
    end
  end

  // Reversal is judged against the move actually taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir      <= DIR_RIGHT;
      last_dir <= DIR_RIGHT;
    end else if (launch) begin
      dir      <= DIR_RIGHT;
      last_dir <= DIR_RIGHT;
    end else if (run) begin
      if (dir_in != dir_opp(applied)) begin
        dir <= dir_in;
      end
      if (step_run) begin
        last_dir <= dir;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_x <= '0;
      seg_y <= '0;
      len   <= '0;
      ate   <= 1'b0;
    end else begin
      ate <= 1'b0;
      if (launch) begin
        for (int k = 0; k < MAX_LEN; k++) begin
          if (k < INIT_LEN) begin
            seg_x[k] <= X_W'(START_X - k);
            seg_y[k] <= Y_W'(START_Y);
          end else begin
            seg_x[k] <= '0;
            seg_y[k] <= '0;
          end
        end
        len <= LEN_INIT;
      end else if (step_run && !collide) begin
        for (int k = MAX_LEN - 1; k > 0; k--) begin
          seg_x[k] <= seg_x[k-1];
          seg_y[k] <= seg_y[k-1];
        end
        seg_x[0] <= nxt.x;
        seg_y[0] <= nxt.y;
        if (grow) begin
          len <= len + LEN_W'(1);
        end
        ate <= apple_eq;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      query_hit <= 1'b0;
    end else begin
      query_hit <= q_hit;
    end
  end

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign length    = len;
  assign alive     = run;
  assign game_over = state == ST_DEAD;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: vector table plus
// hand-written wall, full-length and reset sequences.
module tb_snake_body;

  localparam int U = 0;
  localparam int R = 1;
  localparam int D = 2;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       step;
  logic [1:0] dir_in;
  logic [6:0] apple_x;
  logic [5:0] apple_y;
  logic [6:0] query_x;
  logic [5:0] query_y;
  logic [6:0] head_x;
  logic [5:0] head_y;
  logic [4:0] length;
  logic       ate;
  logic       alive;
  logic       game_over;
  logic       query_hit;

  int n_run;
  int n_fail;

  typedef struct {
    int st, sp, d, ax, ay, qx, qy;
    int hx, hy, len, ate, alv, ovr, qh;
  } vec_t;

  vec_t vecs[$];

  snake_body dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .step      (step),
    .dir_in    (dir_in),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .query_x   (query_x),
    .query_y   (query_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .ate       (ate),
    .alive     (alive),
    .game_over (game_over),
    .query_hit (query_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string name,
    input int hx, input int hy,
    input int len, input int a,
    input int alv, input int ovr,
    input int qh
  );
    logic ok;
    n_run++;
    ok = int'(head_x) == hx
      && int'(head_y) == hy
      && int'(length) == len
      && int'(ate) == a
      && int'(alive) == alv
      && int'(game_over) == ovr
      && (qh < 0 || int'(query_hit) == qh);
    if (!ok) begin
      n_fail++;
      $display(
        "FAIL %s: got head=(%0d,%0d) len=%0d ate=%0d alive=%0d over=%0d qhit=%0d want (%0d,%0d) %0d %0d %0d %0d %0d",
        name, head_x, head_y, length, ate, alive,
        game_over, query_hit, hx, hy, len, a, alv, ovr, qh);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input int st, input int sp, input int d,
    input int ax, input int ay,
    input int qx, input int qy
  );
    start   = 1'(st);
    step    = 1'(sp);
    dir_in  = 2'(d);
    apple_x = 7'(ax);
    apple_y = 6'(ay);
    query_x = 7'(qx);
    query_y = 6'(qy);
  endtask

  task automatic mv(input int d, input int ax, input int ay);
    drive(0, 1, d, ax, ay, 0, 0);
    tick();
  endtask

  task automatic turn(input int d);
    drive(0, 0, d, 40, 40, 0, 0);
    tick();
  endtask

  task automatic fill;
    vecs.push_back('{0,1,R,40,40,0,0,   0,0,0,0,0,0,0});
    vecs.push_back('{1,0,R,40,40,8,10,  10,10,3,0,1,0,0});
    vecs.push_back('{0,0,R,40,40,8,10,  10,10,3,0,1,0,1});
    vecs.push_back('{0,0,R,40,40,7,10,  10,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,40,40,0,0,   11,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,40,40,0,0,   12,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,40,40,0,0,   13,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,40,40,0,0,   14,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,40,40,0,0,   15,10,3,0,1,0,0});
    vecs.push_back('{0,0,L,40,40,0,0,   15,10,3,0,1,0,0});
    vecs.push_back('{0,1,L,40,40,0,0,   16,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,17,10,0,0,   17,10,4,1,1,0,0});
    vecs.push_back('{0,1,R,17,10,0,0,   18,10,4,0,1,0,0});
    vecs.push_back('{0,1,R,19,10,0,0,   19,10,5,1,1,0,0});
    vecs.push_back('{0,0,R,40,40,15,10, 19,10,5,0,1,0,1});
    vecs.push_back('{0,0,D,40,40,0,0,   19,10,5,0,1,0,0});
    vecs.push_back('{0,1,D,40,40,0,0,   19,11,5,0,1,0,0});
    vecs.push_back('{0,0,L,40,40,0,0,   19,11,5,0,1,0,0});
    vecs.push_back('{0,1,L,40,40,0,0,   18,11,5,0,1,0,0});
    vecs.push_back('{0,0,U,40,40,0,0,   18,11,5,0,1,0,0});
    vecs.push_back('{0,1,U,40,40,0,0,   18,11,5,0,0,1,0});
    vecs.push_back('{0,1,R,40,40,17,10, 18,11,5,0,0,1,1});
    vecs.push_back('{1,0,R,40,40,0,0,   10,10,3,0,1,0,0});
    vecs.push_back('{0,1,R,11,10,0,0,   11,10,4,1,1,0,0});
    vecs.push_back('{0,0,D,40,40,0,0,   11,10,4,0,1,0,0});
    vecs.push_back('{0,1,D,40,40,0,0,   11,11,4,0,1,0,0});
    vecs.push_back('{0,0,L,40,40,0,0,   11,11,4,0,1,0,0});
    vecs.push_back('{0,1,L,40,40,0,0,   10,11,4,0,1,0,0});
    vecs.push_back('{0,0,U,40,40,0,0,   10,11,4,0,1,0,0});
    vecs.push_back('{0,1,U,40,40,0,0,   10,10,4,0,1,0,0});
    vecs.push_back('{0,0,R,40,40,0,0,   10,10,4,0,1,0,0});
    vecs.push_back('{0,1,R,11,10,0,0,   10,10,4,0,0,1,0});
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drive(0, 0, R, 40, 40, 0, 0);
    #12;
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    fill();
    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].d,
            vecs[i].ax, vecs[i].ay,
            vecs[i].qx, vecs[i].qy);
      tick();
      chk($sformatf("vec%0d", i),
          vecs[i].hx, vecs[i].hy, vecs[i].len,
          vecs[i].ate, vecs[i].alv, vecs[i].ovr,
          vecs[i].qh);
    end

    // right wall
    drive(1, 0, R, 40, 40, 0, 0);
    tick();
    chk("start_r", 10, 10, 3, 0, 1, 0, -1);
    for (int i = 0; i < 53; i++) mv(R, 40, 40);
    chk("edge_r", 63, 10, 3, 0, 1, 0, -1);
    mv(R, 40, 40);
    chk("wall_r", 63, 10, 3, 0, 0, 1, -1);
    mv(R, 40, 40);
    chk("dead_step", 63, 10, 3, 0, 0, 1, -1);

    // top wall
    drive(1, 0, R, 40, 40, 0, 0);
    tick();
    chk("restart", 10, 10, 3, 0, 1, 0, -1);
    turn(U);
    for (int i = 0; i < 10; i++) mv(U, 40, 40);
    chk("edge_top", 10, 0, 3, 0, 1, 0, -1);
    mv(U, 40, 40);
    chk("wall_top", 10, 0, 3, 0, 0, 1, -1);

    // grow to capacity
    drive(1, 0, R, 40, 40, 0, 0);
    tick();
    chk("start_g", 10, 10, 3, 0, 1, 0, -1);
    for (int i = 0; i < 13; i++) mv(R, 11 + i, 10);
    chk("len_full", 23, 10, 16, 1, 1, 0, -1);
    mv(R, 24, 10);
    chk("ate_max", 24, 10, 16, 1, 1, 0, -1);
    drive(0, 0, R, 40, 40, 24, 10);
    tick();
    chk("ate_clr", 24, 10, 16, 0, 1, 0, 1);

    // asynchronous reset while a step is pending
    drive(0, 1, R, 25, 10, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 0, 0, 0, 0);
    step = 1'b0;
    #2;
    reset_n = 1'b1;
    drive(0, 1, R, 40, 40, 0, 0);
    tick();
    chk("post_rst", 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
